ram_arbiter: RTL and testbench

- Shares one single_port_ram instance (1-cycle registered read, write-first) between NREQ requesters, e.g. CPU data port and screen-refresh DMA.
- Round-robin arbitration with a valid/ready request handshake.
- Routes each read result back to the requester that issued it, one cycle after acceptance.
- Sits between the requesters and the RAM's port A; the RAM clock is the arbiter clock.

---
 rtl/ram_arb_defs.sv | 15 +
 rtl/rr_pick.sv | 32 +++
 rtl/ram_arbiter.sv | 112 +++++++++++
 tb/tb_ram_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_defs.sv
// Shared definitions for the RAM arbiter: index width helper, stats width,
// and the base-offset helper used to pick one requester's slice out of a packed bus.
package ram_arb_defs;

    localparam int STAT_W = 16;

    function automatic int idw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
        return idx * w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// ascending with explicit wrap from N-1 to 0.
module rr_pick #(
    parameter int N   = 2,
    parameter int IDW = 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] idx,
    output logic           any
);

    int unsigned c;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        c   = 0;
        for (int k = 0; k < N; k++) begin
            c = 32'(ptr) + 32'(k);
            if (c >= 32'(N)) c = c - 32'(N);
            if (!any && c < 32'(N) && req[c]) begin
                any    = 1'b1;
                gnt[c] = 1'b1;
                idx    = IDW'(c);
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM (1-cycle read) among NREQ requesters.
// Optional per-requester grant counters are enabled with RAM_ARB_STATS_EN.
module ram_arbiter
    import ram_arb_defs::*;
#(
    parameter int DATA = 16,
    parameter int ADDR = 15,
    parameter int NREQ = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_wr,
    input  logic [NREQ*ADDR-1:0]   req_addr,
    input  logic [NREQ*DATA-1:0]   req_wdata,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA-1:0]        rsp_rdata,
`ifdef RAM_ARB_STATS_EN
    input  logic                   stats_clr,
    output logic [NREQ*STAT_W-1:0] grant_cnt,
`endif
    output logic                   ram_wr,
    output logic [ADDR-1:0]        ram_addr,
    output logic [DATA-1:0]        ram_din,
    input  logic [DATA-1:0]        ram_dout
);

    localparam int IDW = idw_of(NREQ);

    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic            rsp_pend_q, rsp_pend_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [NREQ-1:0] pick_gnt;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;
    logic            accept;

    rr_pick #(.N(NREQ), .IDW(IDW)) u_pick (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Grants are gated by rst_n so nothing reaches the RAM while reset is held.
    assign accept    = pick_any & rst_n;
    assign req_ready = pick_gnt & {NREQ{rst_n}};

    always_comb begin
        ram_wr   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (accept) begin
            ram_wr   = req_wr[pick_idx];
            ram_addr = req_addr[slice_lo(32'(pick_idx), ADDR) +: ADDR];
            ram_din  = req_wdata[slice_lo(32'(pick_idx), DATA) +: DATA];
        end
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        rsp_pend_d = 1'b0;
        rsp_id_d   = rsp_id_q;
        if (accept) begin
            rr_ptr_d   = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
            rsp_pend_d = ~req_wr[pick_idx];
            rsp_id_d   = pick_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            rsp_pend_q <= 1'b0;
            rsp_id_q   <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rsp_pend_q <= rsp_pend_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (rsp_pend_q) rsp_valid[rsp_id_q] = 1'b1;
    end

    assign rsp_rdata = ram_dout;

`ifdef RAM_ARB_STATS_EN
    for (genvar i = 0; i < NREQ; i++) begin : g_cnt
        logic [STAT_W-1:0] cnt_q, cnt_d;

        // Clear beats a same-cycle grant; the counter sticks at all-ones.
        always_comb begin
            cnt_d = cnt_q;
            if (stats_clr) cnt_d = '0;
            else if (accept && pick_idx == IDW'(i) && cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) cnt_q <= '0;
            else        cnt_q <= cnt_d;
        end

        assign grant_cnt[i*STAT_W +: STAT_W] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural write-first RAM model;
// stats checks are included when RAM_ARB_STATS_EN is defined.
module tb_ram_arbiter;

    localparam int DATA = 16;
    localparam int ADDR = 15;
    localparam int NREQ = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_wr;
    logic [NREQ*ADDR-1:0] req_addr;
    logic [NREQ*DATA-1:0] req_wdata;
    logic [NREQ-1:0]      rsp_valid;
    logic [DATA-1:0]      rsp_rdata;
    logic                 ram_wr;
    logic [ADDR-1:0]      ram_addr;
    logic [DATA-1:0]      ram_din;
    logic [DATA-1:0]      ram_dout;
`ifdef RAM_ARB_STATS_EN
    logic                 stats_clr;
    logic [NREQ*16-1:0]   grant_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [DATA-1:0] mem [0:(1<<ADDR)-1];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wr) begin
            mem[ram_addr] <= ram_din;
            ram_dout      <= ram_din;
        end else begin
            ram_dout      <= mem[ram_addr];
        end
    end

    ram_arbiter #(.DATA(DATA), .ADDR(ADDR), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
`ifdef RAM_ARB_STATS_EN
        .stats_clr (stats_clr),
        .grant_cnt (grant_cnt),
`endif
        .ram_wr    (ram_wr),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0]  exp_g [4];
        logic [15:0] exp_d [2];
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_d = '{16'h1111, 16'h2222};

        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_wr    = 2'b11;
        req_addr  = '0;
        req_wdata = '0;
`ifdef RAM_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        #2;
        tick(); tick();
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_ram_wr", 32'(ram_wr), 32'h0);

        req_valid = 2'b00;
        req_wr    = 2'b00;
        rst_n     = 1'b1;
        tick();
        req_valid = 2'b11;
        #1;
        check("first_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
        check("first_rsp", 32'(rsp_valid), 32'h1);
        tick();

        // req0 write 5=BEEF (pointer is 1, only req0 valid)
        req_valid = 2'b01; req_wr = 2'b01;
        req_addr[0 +: ADDR] = 15'd5; req_wdata[0 +: DATA] = 16'hBEEF;
        #1;
        check("wr_ready", 32'(req_ready), 32'h1);
        check("wr_ram_wr", 32'(ram_wr), 32'h1);
        check("wr_ram_addr", 32'(ram_addr), 32'd5);
        check("wr_ram_din", 32'(ram_din), 32'hBEEF);
        tick();
        req_wr = 2'b00;
        #1;
        check("rd_ready", 32'(req_ready), 32'h1);
        check("rd_ram_wr", 32'(ram_wr), 32'h0);
        tick();
        req_valid = 2'b00;
        #1;
        check("rd_rsp_valid", 32'(rsp_valid), 32'h1);
        check("rd_rsp_data", 32'(rsp_rdata), 32'hBEEF);
        check("idle_ram_wr", 32'(ram_wr), 32'h0);
        check("idle_ram_addr", 32'(ram_addr), 32'h0);
        check("idle_ready", 32'(req_ready), 32'h0);
        tick();
        check("idle_rsp", 32'(rsp_valid), 32'h0);

        // Setup: req0 writes 1=1111, then req1 writes 2=2222 -> pointer ends at 0
        req_valid = 2'b01; req_wr = 2'b01;
        req_addr[0 +: ADDR] = 15'd1; req_wdata[0 +: DATA] = 16'h1111;
        tick();
        req_valid = 2'b10; req_wr = 2'b10;
        req_addr[ADDR +: ADDR] = 15'd2; req_wdata[DATA +: DATA] = 16'h2222;
        #1;
        check("setup_w1_ready", 32'(req_ready), 32'h2);
        tick();

        // Contention: both read continuously for 4 cycles
        req_valid = 2'b11; req_wr = 2'b00;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("cont_grant", 32'(req_ready), 32'(exp_g[k]));
            if (k > 0) begin
                check("cont_rsp_valid", 32'(rsp_valid), 32'(exp_g[k-1]));
                check("cont_rsp_data", 32'(rsp_rdata), 32'(exp_d[(k-1)%2]));
            end
            tick();
        end
        req_valid = 2'b00;
        #1;
        check("cont_last_rsp_valid", 32'(rsp_valid), 32'h2);
        check("cont_last_rsp_data", 32'(rsp_rdata), 32'h2222);
        tick();

        // Read-after-write: req1 writes 7=1234, req0 reads 7 next cycle
        req_valid = 2'b10; req_wr = 2'b10;
        req_addr[ADDR +: ADDR] = 15'd7; req_wdata[DATA +: DATA] = 16'h1234;
        #1;
        check("raw_w_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 2'b01; req_wr = 2'b00;
        req_addr[0 +: ADDR] = 15'd7;
        #1;
        check("raw_r_ready", 32'(req_ready), 32'h1);
        check("raw_w_no_rsp", 32'(rsp_valid), 32'h0);
        tick();
        req_valid = 2'b00;
        #1;
        check("raw_rsp_valid", 32'(rsp_valid), 32'h1);
        check("raw_rsp_data", 32'(rsp_rdata), 32'h1234);
        tick();

        // Reset mid-flight: req0 read accepted (pointer -> 1), reset next cycle
        req_valid = 2'b01; req_wr = 2'b00;
        req_addr[0 +: ADDR] = 15'd5;
        tick();
        req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        check("midrst_rsp", 32'(rsp_valid), 32'h0);
        check("midrst_ready", 32'(req_ready), 32'h0);
        tick();
        check("midrst_rsp_hold", 32'(rsp_valid), 32'h0);
        rst_n = 1'b1;
        req_addr[ADDR +: ADDR] = 15'd7;
        req_valid = 2'b11;
        #1;
        check("postrst_grant", 32'(req_ready), 32'h1);
        tick();
        #1;
        check("postrst_rsp0", 32'(rsp_valid), 32'h1);
        check("postrst_data0", 32'(rsp_rdata), 32'hBEEF);
        check("postrst_grant1", 32'(req_ready), 32'h2);
        tick();
        req_valid = 2'b00;
        #1;
        check("postrst_rsp1", 32'(rsp_valid), 32'h2);
        check("postrst_data1", 32'(rsp_rdata), 32'h1234);
        tick();

`ifdef RAM_ARB_STATS_EN
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        req_valid = 2'b01;
        repeat (3) tick();
        req_valid = 2'b10;
        repeat (2) tick();
        req_valid = 2'b00;
        #1;
        check("stats_cnt", grant_cnt, 32'h0002_0003);
        stats_clr = 1'b1;
        req_valid = 2'b01;
        tick();
        stats_clr = 1'b0;
        req_valid = 2'b00;
        check("stats_clr", grant_cnt, 32'h0);
        req_valid = 2'b01;
        repeat (65537) tick();
        req_valid = 2'b00;
        check("stats_sat", grant_cnt, 32'h0000_FFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
